// File: rtl/gt_xctrl_pkg.sv
// gt_xctrl_pkg: shared Gigatron extended-ctrl device codes and SPI engine state type
package gt_xctrl_pkg;
  localparam logic [3:0] DEV_SPI_SEL  = 4'hC;
  localparam logic [3:0] DEV_SPI_CFG  = 4'hD;
  localparam logic [3:0] DEV_SPI_XFER = 4'hE;
  localparam logic [1:0] XCTRL_MATCH  = 2'b00;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_xfer_engine_if.sv
// spi_xfer_engine_if: ctrl-strobe and port-read bus between Gigatron bus logic and the SPI engine
interface spi_xfer_engine_if;
  logic        CTRL_STB;
  logic [15:0] CTRL_A;
  logic        RADDR;
  logic [7:0]  RDATA;
  modport master (output CTRL_STB, CTRL_A, RADDR, input RDATA);
  modport slave  (input CTRL_STB, CTRL_A, RADDR, output RDATA);
endinterface

// File: rtl/spi_xfer_engine_halfbit_timer.sv
// spi_halfbit_timer: emits a one-clock tick every div+1 clocks while enabled
module spi_halfbit_timer #(
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic            clr,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            tick
);
  logic [DIVW-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == '0;
  always_comb cnt_d = (clr || tick) ? div : en ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: SPI master byte shifter driven by Gigatron extended ctrl strobes
module spi_xfer_engine import gt_xctrl_pkg::*; #(
  parameter int NSS  = 2,
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            nRESET,
  spi_xfer_engine_if.slave bus,
  input  logic [NSS-1:0]  MISO,
  output logic            MOSI,
  output logic            SCK,
  output logic [NSS-1:0]  nSS,
  output logic            BUSY
);
  state_t          state_q, state_d;
  logic            cpol_q, cpol_d, cpha_q, cpha_d, ovr_q, ovr_d;
  logic            sck_q, sck_d, mosi_q, mosi_d, smp_q, smp_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [NSS-1:0]  nss_q, nss_d;
  logic [7:0]      sh_q, sh_d, rx_q, rx_d;
  logic [3:0]      edge_q, edge_d;
  logic            hit, sel_hit, cfg_hit, xfer_hit, start, tick, lead, miso_eff, unused;
  assign hit      = bus.CTRL_STB && bus.CTRL_A[3:2] == XCTRL_MATCH;
  assign sel_hit  = hit && bus.CTRL_A[7:4] == DEV_SPI_SEL;
  assign cfg_hit  = hit && bus.CTRL_A[7:4] == DEV_SPI_CFG;
  assign xfer_hit = hit && bus.CTRL_A[7:4] == DEV_SPI_XFER;
  assign start    = state_q == IDLE && xfer_hit;
  assign miso_eff = |(MISO & ~nss_q);
  // edge_q counts edges already made, so the upcoming edge is odd (leading) when edge_q is even
  assign lead     = ~edge_q[0];
  assign unused   = ^bus.CTRL_A[1:0];
  spi_halfbit_timer #(.DIVW(DIVW)) u_timer (
    .CLK(CLK), .nRESET(nRESET), .clr(start), .en(state_q == SHIFT), .div(div_q), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    ovr_d   = ovr_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    smp_d   = smp_q;
    div_d   = div_q;
    nss_d   = nss_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    edge_d  = edge_q;
    if (state_q == IDLE) begin
      if (sel_hit) nss_d = bus.CTRL_A[8 +: NSS];
      if (cfg_hit) begin
        cpol_d = bus.CTRL_A[8];
        cpha_d = bus.CTRL_A[9];
        div_d  = bus.CTRL_A[10 +: DIVW];
        ovr_d  = 1'b0;
        sck_d  = bus.CTRL_A[8];
      end
      if (xfer_hit) begin
        state_d = SHIFT;
        sh_d    = bus.CTRL_A[15:8];
        mosi_d  = bus.CTRL_A[15];
        edge_d  = '0;
      end
    end else begin
      if (sel_hit || cfg_hit || xfer_hit) ovr_d = 1'b1;
      if (tick) begin
        sck_d  = ~sck_q;
        edge_d = edge_q + 4'd1;
        if (lead) begin
          mosi_d = cpha_q ? sh_q[7] : mosi_q;
          smp_d  = cpha_q ? smp_q : miso_eff;
        end else begin
          sh_d   = {sh_q[6:0], cpha_q ? miso_eff : smp_q};
          mosi_d = (!cpha_q && edge_q != 4'd15) ? sh_q[6] : mosi_q;
        end
        if (edge_q == 4'd15) begin
          state_d = IDLE;
          rx_d    = sh_d;
        end
      end
    end
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      smp_q   <= 1'b0;
      div_q   <= '1;
      nss_q   <= '1;
      sh_q    <= '0;
      rx_q    <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      ovr_q   <= ovr_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      smp_q   <= smp_d;
      div_q   <= div_d;
      nss_q   <= nss_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      edge_q  <= edge_d;
    end
  assign BUSY      = state_q == SHIFT;
  assign SCK       = sck_q;
  assign MOSI      = mosi_q;
  assign nSS       = nss_q;
  assign bus.RDATA = bus.RADDR ? {BUSY, ovr_q, cpha_q, cpol_q, 4'b0000} : rx_q;
endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb_spi_xfer_engine: randomized and directed bench with a transfer-level model checked every cycle
module tb_spi_xfer_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lp = 1'b0;
  logic [1:0] miso_drv = 2'b00;
  logic [1:0] miso, nss;
  logic       mosi, sck, busy;
  logic [7:0] pat [2];
  int passes = 0, total = 0;
  spi_xfer_engine_if bus();
  assign miso = lp ? {2{mosi}} : miso_drv;
  spi_xfer_engine #(.NSS(2), .DIVW(4)) dut (
    .CLK(clk), .nRESET(rst_n), .bus(bus), .MISO(miso),
    .MOSI(mosi), .SCK(sck), .nSS(nss), .BUSY(busy)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // transfer-level model: outputs follow from cycles elapsed since the XFER strobe
  bit       mact = 0, mcpol = 0, mcpha = 0, movr = 0, msck = 0, mmosi = 1, started;
  int       mt = 0, mdiv = 15, e, j;
  logic [7:0] mtx = 0, mrx = 0;
  logic [1:0] mnss = 2'b11;

  function automatic logic [7:0] exp_rx();
    logic [7:0] r = 8'h00;
    if (lp) return (mnss != 2'b11) ? mtx : 8'h00;
    for (int i = 0; i < 2; i++) if (!mnss[i]) r |= pat[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mact = 0; mt = 0; mtx = 0; mcpol = 0; mcpha = 0; mdiv = 15;
      mnss = 2'b11; movr = 0; mrx = 0; msck = 0; mmosi = 1;
    end else begin
      started = 0;
      if (bus.CTRL_STB && bus.CTRL_A[3:2] == 2'b00 && bus.CTRL_A[7:4] inside {4'hC, 4'hD, 4'hE}) begin
        if (mact) movr = 1;
        else if (bus.CTRL_A[7:4] == 4'hC) mnss = bus.CTRL_A[9:8];
        else if (bus.CTRL_A[7:4] == 4'hD) begin
          mcpol = bus.CTRL_A[8]; mcpha = bus.CTRL_A[9]; mdiv = int'(bus.CTRL_A[13:10]);
          movr = 0; msck = mcpol;
        end else begin
          mact = 1; mt = 0; mtx = bus.CTRL_A[15:8]; mmosi = mtx[7]; started = 1;
        end
      end
      if (mact && !started) begin
        mt++;
        e = mt / (mdiv + 1);
        msck = mcpol ^ e[0];
        j = mcpha ? ((e + 1) / 2 == 0 ? 0 : (e + 1) / 2 - 1) : (e / 2 > 7 ? 7 : e / 2);
        mmosi = mtx[7 - j];
        if (mt == 16 * (mdiv + 1)) begin mact = 0; mrx = exp_rx(); end
      end
    end
  end

  // slave pattern: present bit 7-k of each pattern until the k-th sample edge has passed
  always @(posedge clk) begin
    int ee, done;
    #1;
    ee = mact ? mt / (mdiv + 1) : 0;
    done = mcpha ? ee / 2 : (ee + 1) / 2;
    if (done > 7) done = 7;
    for (int i = 0; i < 2; i++) miso_drv[i] = pat[i][7 - done];
  end

  always @(negedge clk) begin
    chk("sck", {15'd0, sck}, {15'd0, msck});
    chk("mosi", {15'd0, mosi}, {15'd0, mmosi});
    chk("busy", {15'd0, busy}, {15'd0, mact});
    chk("nss", {14'd0, nss}, {14'd0, mnss});
    chk("rdata", {8'd0, bus.RDATA},
        {8'd0, bus.RADDR ? {mact, movr, mcpha, mcpol, 4'b0000} : mrx});
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic cmd(input logic [15:0] a);
    bus.CTRL_STB = 1'b1; bus.CTRL_A = a;
    step(1);
    bus.CTRL_STB = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin step(1); n++; end
    chk("idle_timeout", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    int n, rises;
    logic prev;
    logic [7:0] lb;
    logic [15:0] a;
    bus.CTRL_STB = 1'b0; bus.CTRL_A = 16'h0000; bus.RADDR = 1'b0;
    pat[0] = 8'h00; pat[1] = 8'h00;
    step(3);
    rst_n = 1'b1;
    chk("rst_rx", {8'd0, bus.RDATA}, 16'h0000);
    bus.RADDR = 1'b1; #1;
    chk("rst_status", {8'd0, bus.RDATA}, 16'h0000);
    chk("rst_sck", {15'd0, sck}, 16'd0);
    chk("rst_nss", {14'd0, nss}, 16'd3);
    chk("rst_mosi", {15'd0, mosi}, 16'd1);
    bus.RADDR = 1'b0;
    step(1);
    // mode 0, DIV=0, loopback on slave 0
    cmd(16'h00D0); cmd(16'h02C0); cmd(16'hA5E4); cmd(16'h00F0);
    lp = 1'b1;
    cmd(16'hA5E0);
    prev = sck; n = 0; rises = 0;
    while (busy && n < 200) begin step(1); n++; if (sck && !prev) rises++; prev = sck; end
    chk("m0_busy_clks", n[15:0], 16'd16);
    chk("m0_rises", rises[15:0], 16'd8);
    chk("m0_rx", {8'd0, bus.RDATA}, 16'h00A5);
    // mode 3, DIV=1, slave 0 drives constant 1
    lp = 1'b0; pat[0] = 8'hFF; pat[1] = 8'h00;
    cmd(16'h07D0);
    chk("m3_sck_idle", {15'd0, sck}, 16'd1);
    cmd(16'h3CE0);
    prev = sck; n = 0; lb = 8'h00;
    while (busy && n < 200) begin step(1); n++; if (prev && !sck) lb = {lb[6:0], mosi}; prev = sck; end
    chk("m3_busy_clks", n[15:0], 16'd32);
    chk("m3_lead_mosi", {8'd0, lb}, 16'h003C);
    chk("m3_rx", {8'd0, bus.RDATA}, 16'h00FF);
    // collision while busy
    lp = 1'b1;
    cmd(16'h0CD0); cmd(16'h5AE0); step(5); cmd(16'hFFE0);
    bus.RADDR = 1'b1; #1;
    chk("ovr_busy_status", {8'd0, bus.RDATA}, 16'h00C0);
    wait_idle(n);
    chk("ovr_idle_status", {8'd0, bus.RDATA}, 16'h0040);
    bus.RADDR = 1'b0; #1;
    chk("ovr_rx", {8'd0, bus.RDATA}, 16'h005A);
    cmd(16'h0CD0);
    bus.RADDR = 1'b1; #1;
    chk("ovr_cleared", {8'd0, bus.RDATA}, 16'h0000);
    // XFER on the falling-BUSY edge is refused, one clock later accepted
    cmd(16'h00D0); cmd(16'h33E0); step(15); cmd(16'h44E0); cmd(16'h55E0);
    chk("b2b_busy", {15'd0, busy}, 16'd1);
    chk("b2b_status", {8'd0, bus.RDATA}, 16'h00C0);
    wait_idle(n);
    bus.RADDR = 1'b0; #1;
    chk("b2b_rx", {8'd0, bus.RDATA}, 16'h0055);
    cmd(16'h00D0);
    // no slave selected
    lp = 1'b0; pat[0] = 8'hFF; pat[1] = 8'hFF;
    cmd(16'h03C0); cmd(16'h77E0); wait_idle(n);
    chk("nosel_rx", {8'd0, bus.RDATA}, 16'h0000);
    // reset mid-transfer
    lp = 1'b1;
    cmd(16'h02C0); cmd(16'h81E0); step(4);
    rst_n = 1'b0; #1;
    chk("rstmid_busy", {15'd0, busy}, 16'd0);
    chk("rstmid_sck", {15'd0, sck}, 16'd0);
    chk("rstmid_rx", {8'd0, bus.RDATA}, 16'h0000);
    @(posedge clk); #2; rst_n = 1'b1;
    cmd(16'h02C0); cmd(16'h96E0); wait_idle(n);
    chk("rstmid_after_rx", {8'd0, bus.RDATA}, 16'h0096);
    // randomized transfers with stray strobes
    for (int it = 0; it < 30; it++) begin
      lp = 1'(($urandom % 2));
      pat[0] = 8'($urandom); pat[1] = 8'($urandom);
      a = 16'($urandom); a[7:0] = 8'hD0; a[13:12] = 2'b00; cmd(a);
      a = 16'($urandom); a[7:0] = 8'hC0; cmd(a);
      a = 16'($urandom); a[7:0] = 8'hE0; cmd(a);
      n = 0;
      while (busy && n < 500) begin
        bus.RADDR = 1'($urandom % 2);
        if ($urandom % 8 == 0) begin
          bus.CTRL_STB = 1'b1; bus.CTRL_A = 16'($urandom);
          if ($urandom % 2 == 1) begin
            bus.CTRL_A[3:2] = 2'b00; bus.CTRL_A[7:4] = 4'hC + 4'($urandom % 3);
          end
        end
        step(1);
        bus.CTRL_STB = 1'b0;
        n++;
      end
      chk("rand_timeout", {15'd0, busy}, 16'd0);
      step(1);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
